mem_loader: RTL and testbench

Byte-stream memory writer that fills a 32-bit-wide RAM word by word, the load-side counterpart to the clocked-read program ROM. It sits between a byte source (UART receiver or debug link) and the write port of the instruction/data memory, and is used at boot to download a program image. A framed image is a 16-bit word count, the data bytes, and a trailing checksum byte. The block assembles little-endian words, issues one write per word, and reports completion or error.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_loader_if.sv | 21 ++
 rtl/mem_loader_packer.sv | 34 +++
 rtl/mem_loader.sv | 148 ++++++++++++++
 tb/tb_mem_loader.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the boot-image memory loader.
package mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_CSUM,
        ST_FIN
    } loader_state_t;

    localparam int unsigned LOADER_LEN_BYTES = 2;
    localparam int unsigned CSUM_WIDTH       = 8;
    localparam int unsigned BYTE_WIDTH       = 8;
    localparam int unsigned WORD_WIDTH       = 32;
    localparam int unsigned LEN_WIDTH        = LOADER_LEN_BYTES * BYTE_WIDTH;

endpackage

// File: rtl/mem_loader_if.sv
// Byte-stream input and memory write port of the loader, grouped as one bus.
interface mem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 9
);
    logic [7:0]            i_byte;
    logic                  i_byte_valid;
    logic                  o_byte_ready;
    logic                  o_wr_en;
    logic [ADDR_WIDTH-1:0] o_wr_addr;
    logic [31:0]           o_wr_data;

    modport slave (
        input  i_byte, i_byte_valid,
        output o_byte_ready, o_wr_en, o_wr_addr, o_wr_data
    );

    modport master (
        output i_byte, i_byte_valid,
        input  o_byte_ready, o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/mem_loader_packer.sv
// Little-endian byte-to-word packer: lane counter, assembly shift register
// and a combinational word-complete flag for the lane-3 accept.
module byte_packer
    import mem_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_accept,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic [WORD_WIDTH-1:0] o_word_c,
    output logic                  o_word_done_c
);
    logic [1:0]                       r_lane;
    logic [WORD_WIDTH-BYTE_WIDTH-1:0] r_word;

    // Newest byte enters at the top so the first byte lands in bits 7:0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lane <= 2'd0;
            r_word <= '0;
        end else if (i_clear) begin
            r_lane <= 2'd0;
            r_word <= '0;
        end else if (i_accept) begin
            r_lane <= r_lane + 2'd1;
            r_word <= {i_byte, r_word[WORD_WIDTH-BYTE_WIDTH-1:BYTE_WIDTH]};
        end
    end

    assign o_word_c      = {i_byte, r_word};
    assign o_word_done_c = i_accept && (r_lane == 2'd3);

endmodule

// File: rtl/mem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte image and
// writes it word by word into a 32-bit RAM starting at address 0.
module mem_loader
    import mem_pkg::*;
#(
    parameter  int unsigned DEPTH      = 512,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    mem_loader_if.slave          bus,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_error,
    output logic [LEN_WIDTH-1:0] o_words_written
);
    loader_state_t         r_state;
    logic                  r_byte_ready;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [WORD_WIDTH-1:0] r_wr_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [CSUM_WIDTH-1:0] r_csum;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_error;
    logic [LEN_WIDTH-1:0]  r_words_written;

    logic                  w_accept;
    logic                  w_start;
    logic                  w_data_accept;
    logic [LEN_WIDTH-1:0]  w_len_full;
    logic [WORD_WIDTH-1:0] w_word;
    logic                  w_word_done;

    assign w_accept      = bus.i_byte_valid && r_byte_ready;
    assign w_start       = i_start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
    assign w_data_accept = w_accept && (r_state == ST_DATA);
    assign w_len_full    = {bus.i_byte, r_len[BYTE_WIDTH-1:0]};

    byte_packer u_packer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_clear       (w_start),
        .i_accept      (w_data_accept),
        .i_byte        (bus.i_byte),
        .o_word_c      (w_word),
        .o_word_done_c (w_word_done)
    );

    // Ready is registered alongside the state so it never looks at valid.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= ST_IDLE;
            r_byte_ready    <= 1'b0;
            r_wr_en         <= 1'b0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_addr          <= '0;
            r_len           <= '0;
            r_csum          <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_error         <= 1'b0;
            r_words_written <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    if (i_start) begin
                        r_state         <= ST_LEN_LO;
                        r_byte_ready    <= 1'b1;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_error         <= 1'b0;
                        r_words_written <= '0;
                        r_addr          <= '0;
                        r_len           <= '0;
                        r_csum          <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (w_accept) begin
                        r_len   <= LEN_WIDTH'(bus.i_byte);
                        r_state <= ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    if (w_accept) begin
                        r_len <= w_len_full;
                        if (w_len_full > LEN_WIDTH'(DEPTH)) begin
                            r_state      <= ST_FIN;
                            r_byte_ready <= 1'b0;
                            r_busy       <= 1'b0;
                            r_done       <= 1'b1;
                            r_error      <= 1'b1;
                        end else if (w_len_full == '0) begin
                            r_state <= ST_CSUM;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        r_csum <= r_csum ^ bus.i_byte;
                        if (w_word_done) begin
                            r_wr_en         <= 1'b1;
                            r_wr_addr       <= r_addr;
                            r_wr_data       <= w_word;
                            r_addr          <= r_addr + ADDR_WIDTH'(1);
                            r_words_written <= r_words_written + LEN_WIDTH'(1);
                            if ((r_words_written + LEN_WIDTH'(1)) == r_len) begin
                                r_state <= ST_CSUM;
                            end
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_accept) begin
                        r_state      <= ST_FIN;
                        r_byte_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_error      <= (bus.i_byte != r_csum);
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_byte_ready <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_byte_ready = r_byte_ready;
    assign bus.o_wr_en      = r_wr_en;
    assign bus.o_wr_addr    = r_wr_addr;
    assign bus.o_wr_data    = r_wr_data;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
    assign o_error          = r_error;
    assign o_words_written  = r_words_written;

endmodule

// File: tb/tb_mem_loader.sv
// Randomized scoreboard bench for mem_loader: images are built from word
// lists, expected writes queued, and a negedge monitor checks every strobe.
module tb_mem_loader;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [15:0] words_written;

    mem_loader_if #(.ADDR_WIDTH(AW)) bus ();

    mem_loader #(.DEPTH(DEPTH)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_start         (start),
        .bus             (bus),
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error),
        .o_words_written (words_written)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int wr_seen = 0;
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.o_wr_en) begin
            wr_seen++;
            if (exp_addr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         bus.o_wr_addr, bus.o_wr_data);
            end else begin
                check("wr_addr", 64'(bus.o_wr_addr), 64'(exp_addr.pop_front()));
                check("wr_data", 64'(bus.o_wr_data), 64'(exp_data.pop_front()));
            end
        end
    end

    function automatic logic [63:0] all_outs();
        return 64'({bus.o_byte_ready, bus.o_wr_en, busy, done, error,
                    bus.o_wr_addr, bus.o_wr_data, words_written});
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_byte_valid = 1'b0;
            start = 1'b0;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy",  64'(busy), 64'd1);
        check("start_ready", 64'(bus.o_byte_ready), 64'd1);
        check("start_clear", 64'({done, error, words_written}), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd, input bit pulse_start);
        bit acc = 1'b0;
        int n = 0;
        while (!acc) begin
            @(negedge clk);
            bus.i_byte       = b;
            bus.i_byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start            = pulse_start && (n == 0);
            acc              = bus.i_byte_valid && bus.o_byte_ready;
            n++;
            if (!acc && n > 100) begin
                tests++;
                fails++;
                $display("FAIL byte_timeout: byte 0x%0h not accepted in %0d cycles", b, n);
                return;
            end
            @(posedge clk);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!done && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    // Reference: image = LE length, LE words, XOR of payload (optionally corrupted).
    task automatic run_image(input logic [31:0] words[$], input bit bad, input bit rnd,
                             input int start_at);
        logic [7:0] img[$];
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        int n = words.size();
        img.push_back(8'(n));
        img.push_back(8'(n >> 8));
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(AW'(i));
            exp_data.push_back(words[i]);
            for (int k = 0; k < 4; k++) begin
                b = 8'(words[i] >> (8 * k));
                img.push_back(b);
                x = x ^ b;
            end
        end
        img.push_back(bad ? (x ^ 8'h5A) : x);
        do_start();
        for (int i = 0; i < img.size(); i++) send_byte(img[i], rnd, i == start_at);
        wait_done();
        check("img_error", 64'(error), 64'(bad));
        check("img_words", 64'(words_written), 64'(n));
        check("img_busy",  64'({busy, bus.o_byte_ready}), 64'd0);
        idle(3);
        check("img_pending_writes", 64'(exp_addr.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] w[$];
        int seen0;
        bus.i_byte = 8'h00;
        bus.i_byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", all_outs(), 64'd0);
        rst = 1'b0;
        idle(2);
        check("post_reset_outs", all_outs(), 64'd0);

        // Good two-word image.
        w = '{32'h12345678, 32'hDEADBEEF};
        run_image(w, 1'b0, 1'b0, -1);

        // Same image, wrong checksum 0x5A: writes stand, error flagged.
        run_image(w, 1'b1, 1'b0, -1);

        // Length 513 exceeds DEPTH: error right after LEN_HI, nothing written.
        do_start();
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        @(negedge clk);
        bus.i_byte_valid = 1'b1;
        check("lenerr_done",  64'(done), 64'd1);
        check("lenerr_error", 64'(error), 64'd1);
        check("lenerr_ready", 64'({bus.o_byte_ready, busy}), 64'd0);
        idle(4);
        check("lenerr_words", 64'(words_written), 64'd0);

        // Zero-length image.
        w = {};
        run_image(w, 1'b0, 1'b0, -1);

        // Randomly gapped one-word image with a stray start pulse mid-load.
        w = '{32'h44332211};
        run_image(w, 1'b0, 1'b1, 3);

        // Reset after 6 payload bytes of a two-word load.
        w = '{32'hCAFEF00D, 32'h0BADC0DE};
        seen0 = wr_seen;
        exp_addr.push_back(AW'(0)); exp_data.push_back(w[0]);
        exp_addr.push_back(AW'(1)); exp_data.push_back(w[1]);
        do_start();
        send_byte(8'h02, 1'b0, 1'b0);
        send_byte(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(8'(w[i/4] >> (8 * (i % 4))), 1'b0, 1'b0);
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midreset_outs", all_outs(), 64'd0);
        repeat (3) @(negedge clk);
        check("midreset_hold", all_outs(), 64'd0);
        check("midreset_writes", 64'(wr_seen - seen0), 64'd1);
        check("midreset_left", 64'(exp_addr.size()), 64'd1);
        exp_addr.delete();
        exp_data.delete();
        rst = 1'b0;
        idle(2);
        check("midreset_after", all_outs(), 64'd0);
        run_image(w, 1'b0, 1'b0, -1);

        // Random images.
        for (int t = 0; t < 4; t++) begin
            w = {};
            for (int i = 0; i < int'($urandom_range(1, 5)); i++) w.push_back($urandom);
            run_image(w, 1'($urandom_range(0, 1)), 1'b1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
